// File: rtl/c_writeback.sv
// c_writeback: buffers accumulator rows from the compute core and writes each one as a single BRAM C word.
// Latency: a row accepted at edge N into an empty FIFO is on the BRAM port in the cycle after edge N+1.
// Backpressure: in_ready drops when the row FIFO is full or every row of the job has been accepted.

module c_wb_fifo #(
    parameter int W     = 256,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push;
    logic         pop;

    // Extra pointer bit separates full from empty when the low bits match.
    assign wr_rdy = !((wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]));
    assign rd_vld = (wr_ptr_q != rd_ptr_q);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
endmodule

module c_writeback #(
    parameter int LANES      = 8,
    parameter int ACC_W      = 32,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ADDR_W-1:0]      cfg_base,
    input  logic [ADDR_W-1:0]      cfg_stride,
    input  logic [15:0]            cfg_rows,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ACC_W-1:0] in_data,
    output logic [ADDR_W-1:0]      bram_c_addr,
    output logic [LANES*ACC_W-1:0] bram_c_din,
    output logic                   bram_c_en,
    output logic                   bram_c_we,
    output logic                   busy,
    output logic                   done
);
    localparam int ROW_W = LANES * ACC_W;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       rows_q, rows_d;
    logic [15:0]       acc_cnt_q, acc_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [ROW_W-1:0]  din_q, din_d;
    logic              en_q, en_d;

    logic              push;
    logic              fifo_wr_rdy;
    logic              fifo_rd_vld;
    logic [ROW_W-1:0]  fifo_rd_dat;

    assign cfg_ready   = (state_q == IDLE);
    assign busy        = (state_q == RUN) || (state_q == FLUSH);
    assign done        = (state_q == DONE);
    assign in_ready    = (state_q == RUN) && fifo_wr_rdy && (acc_cnt_q < rows_q);
    assign push        = in_valid && in_ready;

    assign bram_c_addr = addr_q;
    assign bram_c_din  = din_q;
    assign bram_c_en   = en_q;
    assign bram_c_we   = en_q;

    // The write side drains unconditionally: the head pops every cycle it exists.
    c_wb_fifo #(
        .W     (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat (in_data),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (1'b1),
        .rd_dat (fifo_rd_dat)
    );

    always_comb begin
        state_d   = state_q;
        stride_d  = stride_q;
        rows_d    = rows_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_addr_d = wr_addr_q;
        addr_d    = addr_q;
        din_d     = din_q;
        en_d      = 1'b0;

        if (push) acc_cnt_d = acc_cnt_q + 16'd1;

        if (fifo_rd_vld) begin
            en_d      = 1'b1;
            addr_d    = wr_addr_q;
            din_d     = fifo_rd_dat;
            wr_addr_d = wr_addr_q + stride_q;
            wr_cnt_d  = wr_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    stride_d  = cfg_stride;
                    rows_d    = cfg_rows;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                    wr_addr_d = cfg_base;
                    state_d   = (cfg_rows == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (acc_cnt_q == rows_q) state_d = FLUSH;
            end
            FLUSH: begin
                // wr_cnt only reaches rows on the edge that put the final write on the port.
                if (wr_cnt_q == rows_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            stride_q  <= '0;
            rows_q    <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            wr_addr_q <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            stride_q  <= stride_d;
            rows_q    <= rows_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_addr_q <= wr_addr_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            en_q      <= en_d;
        end
    end
endmodule

// File: tb/tb_c_writeback.sv
// Directed bench for c_writeback: drives job descriptors and rows, records BRAM C writes, checks against hand-derived values.
module tb_c_writeback;
    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [9:0]   cfg_base;
    logic [9:0]   cfg_stride;
    logic [15:0]  cfg_rows;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [9:0]   bram_c_addr;
    logic [255:0] bram_c_din;
    logic         bram_c_en;
    logic         bram_c_we;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [9:0]   w_addr [$];
    logic [255:0] w_dat  [$];
    int           w_cyc  [$];
    int done_cnt, done_cyc, hs_cyc, acc_total, first_acc_cyc;
    int busy_gap, rdy_during, occ_max, we_bad;
    logic rdy_after;

    c_writeback #(
        .LANES      (8),
        .ACC_W      (32),
        .ADDR_W     (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_base    (cfg_base),
        .cfg_stride  (cfg_stride),
        .cfg_rows    (cfg_rows),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .bram_c_addr (bram_c_addr),
        .bram_c_din  (bram_c_din),
        .bram_c_en   (bram_c_en),
        .bram_c_we   (bram_c_we),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] make_row(input int r, input int tag);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'(tag * 4096 + r * 16 + k);
        return d;
    endfunction

    task automatic clear_log();
        w_addr.delete();
        w_dat.delete();
        w_cyc.delete();
        done_cnt = 0; done_cyc = -1; acc_total = 0; first_acc_cyc = -1;
        busy_gap = 0; rdy_during = 0; occ_max = 0; we_bad = 0; rdy_after = 1'b0;
    endtask

    task automatic sample();
        if (bram_c_en === 1'b1) begin
            w_addr.push_back(bram_c_addr);
            w_dat.push_back(bram_c_din);
            w_cyc.push_back(cyc);
            if (bram_c_we !== 1'b1) we_bad++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic run_job(input logic [9:0] base, input logic [9:0] stride, input logic [15:0] rows,
                           input int tag, input bit bubbles, input bit poke_cfg);
        int idx = 0;
        bit pending = 0;
        int post = 0;
        clear_log();
        @(negedge clk);
        cfg_valid = 1'b1; cfg_base = base; cfg_stride = stride; cfg_rows = rows;
        hs_cyc = cyc;
        for (int b = 0; b < 300; b++) begin
            @(negedge clk);
            sample();
            if (b == 0) cfg_valid = 1'b0;
            if (poke_cfg && b == 3) begin cfg_valid = 1'b1; cfg_base = 10'd500; end
            if (poke_cfg && b == 4) cfg_valid = 1'b0;
            if (done_cnt == 0) begin
                if (!busy) busy_gap++;
                if (cfg_ready) rdy_during++;
            end else if (post == 1) begin
                rdy_after = cfg_ready;
            end
            if (pending) begin idx++; pending = 0; end
            if (idx < int'(rows)) begin
                in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = make_row(idx, tag);
            end else begin
                in_valid = !bubbles;
                in_data  = '1;
            end
            if (in_valid && in_ready) begin
                pending = 1;
                acc_total++;
                if (acc_total == 1) first_acc_cyc = cyc;
            end
            if (acc_total - w_addr.size() > occ_max) occ_max = acc_total - w_addr.size();
            if (done_cnt > 0) begin
                post++;
                if (post == 4) break;
            end
        end
        in_valid = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cfg_valid = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_rows = '0;
        in_valid = 1'b0; in_data = '0;
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
        n_cmp++; if ({in_ready, bram_c_en, bram_c_we, busy, done} !== 5'b0) begin n_err++;
            $display("FAIL reset_ctrl_outputs got=%b want=00000", {in_ready, bram_c_en, bram_c_we, busy, done}); end
        n_cmp++; if (bram_c_addr !== 10'd0 || bram_c_din !== 256'd0) begin n_err++;
            $display("FAIL reset_addr_din got addr=%0d din=%h want 0", bram_c_addr, bram_c_din); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bram_c_en !== 1'b0 || cfg_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_release en=%b cfg_ready=%b want en=0 cfg_ready=1", bram_c_en, cfg_ready); end
    endtask

    task automatic test_basic();
        run_job(10'd0, 10'd1, 16'd8, 0, 1'b0, 1'b0);
        n_cmp++; if (acc_total !== 8) begin n_err++; $display("FAIL basic_accepted got=%0d want=8", acc_total); end
        n_cmp++; if (w_addr.size() !== 8) begin n_err++; $display("FAIL basic_write_count got=%0d want=8", w_addr.size()); end
        for (int i = 0; i < 8 && i < w_addr.size(); i++) begin
            n_cmp++; if (w_addr[i] !== 10'(i) || w_dat[i] !== make_row(i, 0)) begin n_err++;
                $display("FAIL basic_write%0d got addr=%0d din=%h want addr=%0d din=%h", i, w_addr[i], w_dat[i], i, make_row(i, 0)); end
            n_cmp++; if (w_cyc[i] !== w_cyc[0] + i) begin n_err++;
                $display("FAIL basic_consecutive%0d got cyc=%0d want=%0d", i, w_cyc[i], w_cyc[0] + i); end
        end
        n_cmp++; if (w_cyc.size() > 0 && w_cyc[0] !== first_acc_cyc + 2) begin n_err++;
            $display("FAIL basic_latency got=%0d want=%0d", w_cyc[0], first_acc_cyc + 2); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
        n_cmp++; if (w_cyc.size() > 0 && done_cyc !== w_cyc[w_cyc.size()-1] + 1) begin n_err++;
            $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, w_cyc[w_cyc.size()-1] + 1); end
        n_cmp++; if (busy_gap !== 0) begin n_err++; $display("FAIL basic_busy_gap got=%0d want=0", busy_gap); end
        n_cmp++; if (rdy_after !== 1'b1) begin n_err++; $display("FAIL basic_cfg_ready_after got=%b want=1", rdy_after); end
        n_cmp++; if (we_bad !== 0) begin n_err++; $display("FAIL basic_we_follows_en got=%0d want=0", we_bad); end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_a [4];
        exp_a[0] = 10'd1020; exp_a[1] = 10'd0; exp_a[2] = 10'd4; exp_a[3] = 10'd8;
        run_job(10'd1020, 10'd4, 16'd4, 1, 1'b0, 1'b0);
        n_cmp++; if (w_addr.size() !== 4) begin n_err++; $display("FAIL wrap_write_count got=%0d want=4", w_addr.size()); end
        for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
            n_cmp++; if (w_addr[i] !== exp_a[i] || w_dat[i] !== make_row(i, 1)) begin n_err++;
                $display("FAIL wrap_write%0d got addr=%0d want addr=%0d", i, w_addr[i], exp_a[i]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL wrap_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        run_job(10'd200, 10'd3, 16'd6, 3, 1'b1, 1'b0);
        n_cmp++; if (acc_total !== 6) begin n_err++; $display("FAIL bp_accepted got=%0d want=6", acc_total); end
        n_cmp++; if (w_addr.size() !== 6) begin n_err++; $display("FAIL bp_write_count got=%0d want=6", w_addr.size()); end
        for (int i = 0; i < 6 && i < w_addr.size(); i++) begin
            n_cmp++; if (w_addr[i] !== 10'(200 + 3 * i) || w_dat[i] !== make_row(i, 3)) begin n_err++;
                $display("FAIL bp_write%0d got addr=%0d din=%h want addr=%0d din=%h", i, w_addr[i], w_dat[i], 200 + 3 * i, make_row(i, 3)); end
        end
        n_cmp++; if (occ_max > 4) begin n_err++; $display("FAIL bp_occupancy got=%0d want<=4", occ_max); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_zero_and_busy_cfg();
        run_job(10'd50, 10'd1, 16'd0, 4, 1'b0, 1'b0);
        n_cmp++; if (w_addr.size() !== 0) begin n_err++; $display("FAIL zero_rows_writes got=%0d want=0", w_addr.size()); end
        n_cmp++; if (done_cnt !== 1 || done_cyc !== hs_cyc + 1) begin n_err++;
            $display("FAIL zero_rows_done got count=%0d cyc=%0d want count=1 cyc=%0d", done_cnt, done_cyc, hs_cyc + 1); end
        run_job(10'd10, 10'd2, 16'd4, 7, 1'b0, 1'b1);
        n_cmp++; if (rdy_during !== 0) begin n_err++; $display("FAIL busy_cfg_ready got=%0d want=0", rdy_during); end
        n_cmp++; if (w_addr.size() !== 4) begin n_err++; $display("FAIL busy_cfg_write_count got=%0d want=4", w_addr.size()); end
        for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
            n_cmp++; if (w_addr[i] !== 10'(10 + 2 * i) || w_dat[i] !== make_row(i, 7)) begin n_err++;
                $display("FAIL busy_cfg_write%0d got addr=%0d want addr=%0d", i, w_addr[i], 10 + 2 * i); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL busy_cfg_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int idx = 0;
        bit pending = 0;
        clear_log();
        @(negedge clk);
        cfg_valid = 1'b1; cfg_base = 10'd0; cfg_stride = 10'd1; cfg_rows = 16'd8;
        for (int b = 0; b < 100; b++) begin
            @(negedge clk);
            sample();
            cfg_valid = 1'b0;
            if (pending) begin idx++; pending = 0; end
            in_valid = (idx < 8);
            in_data  = make_row(idx, 5);
            if (in_valid && in_ready) pending = 1;
            if (w_addr.size() == 3) break;
        end
        n_cmp++; if (w_addr.size() !== 3) begin n_err++; $display("FAIL midrst_prewrites got=%0d want=3", w_addr.size()); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bram_c_en, bram_c_we, busy, done} !== 4'b0 || cfg_ready !== 1'b1) begin n_err++;
            $display("FAIL midrst_immediate got en/we/busy/done=%b cfg_ready=%b want 0000 and 1",
                     {bram_c_en, bram_c_we, busy, done}, cfg_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            sample();
        end
        n_cmp++; if (done_cnt !== 0 || w_addr.size() !== 0) begin n_err++;
            $display("FAIL midrst_abandon got done=%0d writes=%0d want 0 0", done_cnt, w_addr.size()); end
        run_job(10'd100, 10'd1, 16'd2, 6, 1'b0, 1'b0);
        n_cmp++; if (w_addr.size() !== 2) begin n_err++; $display("FAIL midrst_fresh_count got=%0d want=2", w_addr.size()); end
        for (int i = 0; i < 2 && i < w_addr.size(); i++) begin
            n_cmp++; if (w_addr[i] !== 10'(100 + i) || w_dat[i] !== make_row(i, 6)) begin n_err++;
                $display("FAIL midrst_fresh%0d got addr=%0d want addr=%0d", i, w_addr[i], 100 + i); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL midrst_fresh_done got=%0d want=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_busy_cfg();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
